// File: rtl/loop_controller_pkg.sv
// Shared definitions for the Brainfuck loop controller: FSM state encoding
// and the stack-full depth constant.
package loop_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POP   = 2'd1,
    ST_SKIP  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  // The depth value that means "every stack entry is occupied".
  function automatic int unsigned depth_full(input int unsigned depth_pow);
    return 32'd1 << depth_pow;
  endfunction

endpackage

// File: rtl/loop_controller_nest_counter.sv
// Skip-mode bracket nesting counter. It can be cleared, loaded with 1,
// incremented or decremented, and it flags the all-ones and ==1 values.
module nest_counter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         clr,
  input  logic         load_one,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         at_max,
  output logic         at_one
);

  always_ff @(posedge CLK) begin
    if (RESET || clr)  count <= '0;
    else if (load_one) count <= W'(1);
    else if (inc)      count <= count + W'(1);
    else if (dec)      count <= count - W'(1);
  end

  assign at_max = (count == {W{1'b1}});
  assign at_one = (count == W'(1));

endmodule

// File: rtl/loop_controller.sv
// Loop controller for the Brainfuck core: handles '[' and ']' by pushing and
// popping loop-entry addresses, redirecting the PC and running forward skip.
module loop_controller
  import loop_ctl_pkg::*;
#(
  parameter int WIDTH      = 11,
  parameter int DEPTH_POW  = 7,
  parameter int NEST_WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             OP_VALID,
  input  logic             OP_OPEN,
  input  logic             OP_CLOSE,
  input  logic             CELL_ZERO,
  input  logic [WIDTH-1:0] PC,
  output logic             OP_ACK,
  output logic             SKIP,
  output logic             PC_LOAD,
  output logic [WIDTH-1:0] PC_TARGET,
  output logic             STK_PUSH,
  output logic             STK_POP,
  output logic [WIDTH-1:0] STK_D,
  input  logic [WIDTH-1:0] STK_Q,
  output logic             FAULT
);

  localparam logic [DEPTH_POW:0] FULL = (DEPTH_POW + 1)'(depth_full(DEPTH_POW));

  // Handshake: an op is held on OP_VALID/PC until the controller raises OP_ACK
  // in a cycle where OP_VALID is high; the op is consumed at that clock edge.
  state_t               state, state_nx;
  logic [DEPTH_POW:0]   depth;
  logic                 cz_latch;
  logic                 bad_op;
  logic                 nest_clr, nest_load, nest_inc, nest_dec;
  logic                 nest_max, nest_one;
  logic [NEST_WIDTH-1:0] nest;

  nest_counter #(.W(NEST_WIDTH)) u_nest (
    .CLK      (CLK),
    .RESET    (RESET),
    .clr      (nest_clr),
    .load_one (nest_load),
    .inc      (nest_inc),
    .dec      (nest_dec),
    .count    (nest),
    .at_max   (nest_max),
    .at_one   (nest_one)
  );

  assign bad_op = OP_VALID && OP_OPEN && OP_CLOSE;

  always_comb begin
    state_nx  = state;
    OP_ACK    = 1'b0;
    SKIP      = 1'b0;
    PC_LOAD   = 1'b0;
    PC_TARGET = '0;
    STK_PUSH  = 1'b0;
    STK_POP   = 1'b0;
    STK_D     = '0;
    FAULT     = 1'b0;
    nest_clr  = 1'b0;
    nest_load = 1'b0;
    nest_inc  = 1'b0;
    nest_dec  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bad_op) state_nx = ST_FAULT;
        else if (OP_VALID && OP_OPEN) begin
          if (CELL_ZERO) begin
            OP_ACK    = 1'b1;
            nest_load = 1'b1;
            state_nx  = ST_SKIP;
          end else if (depth == FULL) begin
            state_nx = ST_FAULT;
          end else begin
            STK_PUSH = 1'b1;
            STK_D    = PC;
            OP_ACK   = 1'b1;
          end
        end else if (OP_VALID && OP_CLOSE) begin
          if (depth == '0) state_nx = ST_FAULT;
          else begin
            STK_POP  = 1'b1;
            state_nx = ST_POP;
          end
        end else if (OP_VALID) begin
          OP_ACK = 1'b1;
        end
      end
      ST_POP: begin
        // STK_Q now holds the popped entry; only a live loop jumps back.
        if (bad_op) state_nx = ST_FAULT;
        else begin
          OP_ACK    = 1'b1;
          PC_LOAD   = !cz_latch;
          PC_TARGET = cz_latch ? '0 : STK_Q;
          state_nx  = ST_IDLE;
        end
      end
      ST_SKIP: begin
        SKIP = 1'b1;
        if (bad_op) state_nx = ST_FAULT;
        else if (OP_VALID && OP_OPEN) begin
          if (nest_max) state_nx = ST_FAULT;
          else begin
            OP_ACK   = 1'b1;
            nest_inc = 1'b1;
          end
        end else if (OP_VALID && OP_CLOSE) begin
          OP_ACK = 1'b1;
          if (nest_one) begin
            nest_clr = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            nest_dec = 1'b1;
          end
        end else if (OP_VALID) begin
          OP_ACK = 1'b1;
        end
      end
      default: begin
        FAULT = 1'b1;
      end
    endcase
    if (state_nx == ST_FAULT) nest_clr = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= ST_IDLE;
      depth    <= '0;
      cz_latch <= 1'b0;
    end else begin
      state <= state_nx;
      if (STK_PUSH) depth <= depth + 1'b1;
      else if (STK_POP) begin
        depth    <= depth - 1'b1;
        cz_latch <= CELL_ZERO;
      end
    end
  end

endmodule

// File: tb/tb_loop_controller.sv
// Directed bench for loop_controller with a behavioural loop-address stack.
module tb_loop_controller;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        OP_VALID = 1'b0, OP_OPEN = 1'b0, OP_CLOSE = 1'b0, CELL_ZERO = 1'b0;
  logic [10:0] PC = '0;
  logic        OP_ACK, SKIP, PC_LOAD, STK_PUSH, STK_POP, FAULT;
  logic [10:0] PC_TARGET, STK_D, STK_Q;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  loop_controller dut (
    .CLK(CLK), .RESET(RESET), .OP_VALID(OP_VALID), .OP_OPEN(OP_OPEN),
    .OP_CLOSE(OP_CLOSE), .CELL_ZERO(CELL_ZERO), .PC(PC), .OP_ACK(OP_ACK),
    .SKIP(SKIP), .PC_LOAD(PC_LOAD), .PC_TARGET(PC_TARGET), .STK_PUSH(STK_PUSH),
    .STK_POP(STK_POP), .STK_D(STK_D), .STK_Q(STK_Q), .FAULT(FAULT)
  );

  // Stack: pop presents the former top entry from the popping edge onward.
  logic [10:0] mem [0:127];
  int          sp;
  logic [10:0] q_r;
  assign STK_Q = q_r;
  always @(posedge CLK) begin
    if (RESET) begin
      sp  <= 0;
      q_r <= '0;
    end else if (STK_PUSH && sp < 128) begin
      mem[sp] <= STK_D;
      sp      <= sp + 1;
    end else if (STK_POP && sp > 0) begin
      q_r <= mem[sp-1];
      sp  <= sp - 1;
    end
  end

  task automatic drive(input logic v, input logic o, input logic c,
                       input logic z, input logic [10:0] p);
    OP_VALID = v; OP_OPEN = o; OP_CLOSE = c; CELL_ZERO = z; PC = p;
    #3;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, 0, 0, 0, 0);
    n_checks++;
    if ({OP_ACK, SKIP, PC_LOAD, STK_PUSH, STK_POP, FAULT} !== 6'b0 || PC_TARGET !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ack=%b skip=%b load=%b push=%b pop=%b fault=%b tgt=%0d, want all 0",
               OP_ACK, SKIP, PC_LOAD, STK_PUSH, STK_POP, FAULT, PC_TARGET);
    end
    n_checks++;
    if (dut.depth !== 8'd0) begin n_fail++; $display("FAIL reset_depth: got %0d want 0", dut.depth); end
    drive(1, 0, 0, 0, 11'd3);
    n_checks++;
    if (OP_ACK !== 1'b1 || STK_PUSH !== 1'b0 || STK_POP !== 1'b0) begin
      n_fail++; $display("FAIL plain_op: ack=%b push=%b pop=%b want 1 0 0", OP_ACK, STK_PUSH, STK_POP);
    end
    step();
  endtask

  task automatic test_push_pop();
    drive(1, 1, 0, 0, 11'd5);
    n_checks++;
    if (STK_PUSH !== 1'b1 || STK_D !== 11'd5 || OP_ACK !== 1'b1) begin
      n_fail++; $display("FAIL open_push: push=%b d=%0d ack=%b want 1 5 1", STK_PUSH, STK_D, OP_ACK);
    end
    step();
    n_checks++;
    if (dut.depth !== 8'd1) begin n_fail++; $display("FAIL depth_after_push: got %0d want 1", dut.depth); end
    drive(1, 0, 1, 0, 11'd9);
    n_checks++;
    if (STK_POP !== 1'b1 || OP_ACK !== 1'b0 || PC_LOAD !== 1'b0) begin
      n_fail++; $display("FAIL close_pop: pop=%b ack=%b load=%b want 1 0 0", STK_POP, OP_ACK, PC_LOAD);
    end
    step();
    n_checks++;
    if (OP_ACK !== 1'b1 || PC_LOAD !== 1'b1 || PC_TARGET !== 11'd5 || STK_POP !== 1'b0) begin
      n_fail++; $display("FAIL close_jump: ack=%b load=%b tgt=%0d pop=%b want 1 1 5 0",
                         OP_ACK, PC_LOAD, PC_TARGET, STK_POP);
    end
    n_checks++;
    if (dut.depth !== 8'd0) begin n_fail++; $display("FAIL depth_after_pop: got %0d want 0", dut.depth); end
    step();
    // Loop exit: ']' with a zero cell pops but falls through.
    drive(1, 1, 0, 0, 11'd7);
    step();
    drive(1, 0, 1, 1, 11'd12);
    step();
    n_checks++;
    if (OP_ACK !== 1'b1 || PC_LOAD !== 1'b0 || PC_TARGET !== 11'd0) begin
      n_fail++; $display("FAIL close_fallthrough: ack=%b load=%b tgt=%0d want 1 0 0", OP_ACK, PC_LOAD, PC_TARGET);
    end
    step();
  endtask

  task automatic test_skip();
    logic [3:0] ops_o, ops_c;
    logic [7:0] exp_nest [0:3];
    ops_o = 4'b0010; ops_c = 4'b1100;   // '+' '[' '-' ']' in order (bit i = op i)
    ops_c = 4'b1000;
    exp_nest[0] = 8'd1; exp_nest[1] = 8'd2; exp_nest[2] = 8'd2; exp_nest[3] = 8'd1;
    drive(1, 1, 0, 1, 11'd5);
    n_checks++;
    if (OP_ACK !== 1'b1 || STK_PUSH !== 1'b0) begin
      n_fail++; $display("FAIL skip_enter: ack=%b push=%b want 1 0", OP_ACK, STK_PUSH);
    end
    step();
    n_checks++;
    if (dut.nest !== 8'd1) begin n_fail++; $display("FAIL skip_nest_init: got %0d want 1", dut.nest); end
    for (int i = 0; i < 4; i++) begin
      drive(1, ops_o[i], ops_c[i], 1, 11'(6 + i));
      n_checks++;
      if (SKIP !== 1'b1 || OP_ACK !== 1'b1 || STK_PUSH !== 1'b0 || STK_POP !== 1'b0) begin
        n_fail++; $display("FAIL skip_op%0d: skip=%b ack=%b push=%b pop=%b want 1 1 0 0",
                           i, SKIP, OP_ACK, STK_PUSH, STK_POP);
      end
      step();
      n_checks++;
      if (dut.nest !== exp_nest[i]) begin
        n_fail++; $display("FAIL skip_nest%0d: got %0d want %0d", i, dut.nest, exp_nest[i]);
      end
    end
    drive(1, 0, 1, 1, 11'd10);
    n_checks++;
    if (SKIP !== 1'b1 || OP_ACK !== 1'b1 || STK_POP !== 1'b0) begin
      n_fail++; $display("FAIL skip_exit_op: skip=%b ack=%b pop=%b want 1 1 0", SKIP, OP_ACK, STK_POP);
    end
    step();
    drive(0, 0, 0, 0, 0);
    n_checks++;
    if (SKIP !== 1'b0 || dut.nest !== 8'd0 || dut.depth !== 8'd0) begin
      n_fail++; $display("FAIL skip_exit: skip=%b nest=%0d depth=%0d want 0 0 0", SKIP, dut.nest, dut.depth);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    drive(1, 0, 1, 0, 11'd4);
    n_checks++;
    if (OP_ACK !== 1'b0 || STK_POP !== 1'b0) begin
      n_fail++; $display("FAIL underflow_op: ack=%b pop=%b want 0 0", OP_ACK, STK_POP);
    end
    step();
    drive(1, 1, 0, 0, 11'd6);
    n_checks++;
    if (FAULT !== 1'b1 || OP_ACK !== 1'b0 || STK_PUSH !== 1'b0) begin
      n_fail++; $display("FAIL underflow_sticky: fault=%b ack=%b push=%b want 1 0 0", FAULT, OP_ACK, STK_PUSH);
    end
    step();
    do_reset();
    drive(0, 0, 0, 0, 0);
    n_checks++;
    if (FAULT !== 1'b0) begin n_fail++; $display("FAIL fault_cleared: got %b want 0", FAULT); end
  endtask

  task automatic test_overflow();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      drive(1, 1, 0, 0, 11'(i));
      if (STK_PUSH !== 1'b1 || OP_ACK !== 1'b1 || STK_D !== 11'(i)) bad++;
      step();
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL overflow_fill: %0d bad pushes, want 0", bad); end
    drive(1, 1, 0, 0, 11'd200);
    n_checks++;
    if (STK_PUSH !== 1'b0 || OP_ACK !== 1'b0) begin
      n_fail++; $display("FAIL overflow_push: push=%b ack=%b want 0 0", STK_PUSH, OP_ACK);
    end
    step();
    n_checks++;
    if (FAULT !== 1'b1 || dut.depth !== 8'd128) begin
      n_fail++; $display("FAIL overflow_fault: fault=%b depth=%0d want 1 128", FAULT, dut.depth);
    end
  endtask

  task automatic test_nest_sat();
    do_reset();
    drive(1, 1, 0, 1, 11'd1);
    step();
    for (int i = 0; i < 254; i++) begin
      drive(1, 1, 0, 1, 11'd2);
      step();
    end
    n_checks++;
    if (dut.nest !== 8'd255 || SKIP !== 1'b1) begin
      n_fail++; $display("FAIL nest_fill: nest=%0d skip=%b want 255 1", dut.nest, SKIP);
    end
    drive(1, 1, 0, 1, 11'd3);
    n_checks++;
    if (OP_ACK !== 1'b0) begin n_fail++; $display("FAIL nest_sat_ack: got %b want 0", OP_ACK); end
    step();
    n_checks++;
    if (FAULT !== 1'b1 || SKIP !== 1'b0) begin
      n_fail++; $display("FAIL nest_sat_fault: fault=%b skip=%b want 1 0", FAULT, SKIP);
    end
  endtask

  task automatic test_both_brackets();
    do_reset();
    drive(1, 1, 1, 0, 11'd8);
    n_checks++;
    if (OP_ACK !== 1'b0 || STK_PUSH !== 1'b0 || STK_POP !== 1'b0) begin
      n_fail++; $display("FAIL both_op: ack=%b push=%b pop=%b want 0 0 0", OP_ACK, STK_PUSH, STK_POP);
    end
    step();
    n_checks++;
    if (FAULT !== 1'b1) begin n_fail++; $display("FAIL both_fault: got %b want 1", FAULT); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 1, 0, 0, 11'd5);
    step();
    drive(1, 0, 1, 0, 11'd9);
    step();
    RESET = 1'b1;                       // now in POP
    step();
    RESET = 1'b0;
    drive(0, 0, 0, 0, 0);
    n_checks++;
    if ({OP_ACK, SKIP, PC_LOAD, STK_PUSH, STK_POP, FAULT} !== 6'b0 || dut.depth !== 8'd0) begin
      n_fail++; $display("FAIL reset_in_pop: ack=%b load=%b depth=%0d want 0 0 0", OP_ACK, PC_LOAD, dut.depth);
    end
    drive(1, 1, 0, 1, 11'd5);
    step();
    drive(1, 1, 0, 1, 11'd6);
    step();
    RESET = 1'b1;                       // now in SKIP, nest 2
    drive(1, 0, 0, 1, 11'd7);
    step();
    RESET = 1'b0;
    drive(0, 0, 0, 0, 0);
    n_checks++;
    if (SKIP !== 1'b0 || OP_ACK !== 1'b0 || dut.nest !== 8'd0 || FAULT !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_skip: skip=%b ack=%b nest=%0d fault=%b want 0 0 0 0",
                         SKIP, OP_ACK, dut.nest, FAULT);
    end
    drive(1, 1, 0, 0, 11'd2);
    n_checks++;
    if (STK_PUSH !== 1'b1 || STK_D !== 11'd2 || OP_ACK !== 1'b1) begin
      n_fail++; $display("FAIL push_after_reset: push=%b d=%0d ack=%b want 1 2 1", STK_PUSH, STK_D, OP_ACK);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_skip();
    test_underflow();
    test_overflow();
    test_nest_sat();
    test_both_brackets();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/loop_controller.md
Name: loop_controller

Overview:
- Sequences the loop-address stack for the Brainfuck core; handles `[` and `]`.
- Pushes loop-entry addresses, pops them at loop end, and redirects the PC.
- Runs forward-skip mode when `[` sees a zero cell.
- Sits between the instruction decoder/fetch unit and the stack; the stack shares CLK/RESET.

Parameters:
- WIDTH, 11: PC/address width; also the stack entry width.
- DEPTH_POW, 7: log2 of stack depth. Stack holds 2^DEPTH_POW entries.
- NEST_WIDTH, 8: width of the skip-mode nesting counter.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- OP_VALID  in  1  decoder presents an instruction.
- OP_OPEN  in  1  the instruction is `[` (qualified by OP_VALID).
- OP_CLOSE  in  1  the instruction is `]` (qualified by OP_VALID).
- CELL_ZERO  in  1  current data cell == 0.
- PC  in  WIDTH  address of the presented instruction.
- OP_ACK  out  1  instruction consumed; fetch may advance.
- SKIP  out  1  skip mode; datapath suppresses execution of acked ops.
- PC_LOAD  out  1  fetch loads PC_TARGET instead of PC+1.
- PC_TARGET  out  WIDTH  jump address.
- STK_PUSH  out  1  stack push strobe.
- STK_POP  out  1  stack pop strobe.
- STK_D  out  WIDTH  push data.
- STK_Q  in  WIDTH  stack output. After a pop strobe at edge N, STK_Q holds the popped (former top) entry from edge N onward.
- FAULT  out  1  sticky overflow/underflow/nest error.

Behaviour:
- Reset state: IDLE, depth counter = 0, nest counter = 0, FAULT = 0, CELL_ZERO latch = 0. All strobes and ACK deassert. Reset mid-skip or mid-pop aborts cleanly.
- Outputs are combinational from state, counters and inputs. The stack samples strobes at the same edge the controller changes state.
- States: IDLE, POP, SKIP, FAULT.
- IDLE, no OP_VALID: all strobes 0.
- IDLE, non-bracket op: OP_ACK = 1; no other action.
- IDLE, `[` with CELL_ZERO = 0:
  - depth == 2^DEPTH_POW: go FAULT, no ACK.
  - else: STK_PUSH = 1, STK_D = PC, OP_ACK = 1, depth +1. Single cycle.
- IDLE, `[` with CELL_ZERO = 1: OP_ACK = 1, nest = 1, go SKIP. No push.
- IDLE, `]`:
  - depth == 0: go FAULT, no ACK.
  - else: STK_POP = 1, depth -1, latch CELL_ZERO, go POP. OP_ACK = 0.
- POP (one cycle):
  - OP_ACK = 1.
  - If latched CELL_ZERO = 0: PC_LOAD = 1, PC_TARGET = STK_Q. Jumps to the `[`, which re-evaluates and re-pushes.
  - Else: PC_LOAD = 0 (fall through).
  - Next state IDLE. `]` latency is 2 cycles; `[` latency is 1 cycle.
- SKIP:
  - SKIP = 1, OP_ACK = OP_VALID for every op.
  - `[` increments nest; nest at all-ones → go FAULT.
  - `]` with nest == 1 → nest = 0, go IDLE. That `]` is acked and not executed.
  - `]` with nest > 1 → nest -1.
  - Stack is never touched in SKIP.
- FAULT: all strobes, SKIP and OP_ACK are 0; FAULT = 1. Held until RESET.
- OP_OPEN and OP_CLOSE both high: treated as fault in any state.
- PC_TARGET = 0 whenever PC_LOAD = 0.
- Depth counter is DEPTH_POW+1 bits, range 0..2^DEPTH_POW; it never wraps.

Decomposition:
- Package `loop_ctl_pkg`: state encoding constants (IDLE, POP, SKIP, FAULT) and the depth-full constant (1 << DEPTH_POW).
- Sub-module `nest_counter`: skip-mode up/down counter with load-1, saturation detect and ==1 compare.
- Stack stays a separate instance wired by the parent.

Test Plan:
- Reset, then `[` at PC=5 with cell 3 → STK_PUSH=1, STK_D=5, ACK same cycle, depth 1.
- Then `]` at PC=9 with cell 1 → cycle 1: STK_POP=1, no ACK; cycle 2: ACK, PC_LOAD=1, PC_TARGET=5, depth 0.
- `[` at PC=5, cell 0 → SKIP; feed `+ [ - ] ]` → SKIP high throughout, nest goes 1,1,2,2,1,0. Exits IDLE after the second `]`; no stack strobes.
- `]` at depth 0 → FAULT=1, no ACK. Later ops ignored until RESET clears FAULT.
- 128 consecutive `[` with cell≠0 succeed; the 129th → FAULT, no push.
- RESET asserted during POP or SKIP → next cycle IDLE, depth 0, all outputs 0. A subsequent `[` at PC=2 pushes 2.
